pwm_capture: RTL

Measures an incoming PWM signal. For each complete period it reports the high time and the period, both counted in `clk` cycles, and the duty cycle in 0.1 % steps (0–1000). It is the receive side for the 0.1 %-resolution PWM generators used for servos, DC motors and LEDs. Typical uses are loopback checking of generated PWM and reading external RC/servo command pulses so they can be shown on the FND.

---
 rtl/pwm_capture_if.sv | 25 ++
 rtl/pwm_capture.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture_if.sv
// Measurement bus between a PWM source/observer and pwm_capture.
// Latency: none, wires only.
// Backpressure: none; results are presented with a one-cycle valid pulse.
interface pwm_capture_if #(
  parameter int CNT_W = 24
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [9:0]       duty_x10;
  logic             valid;
  logic             no_signal;

  // Observer side: drives the PWM input, receives measurements.
  modport master (
    output pwm_in,
    input  high_cnt, period_cnt, duty_x10, valid, no_signal
  );

  // Capture block side.
  modport slave (
    input  pwm_in,
    output high_cnt, period_cnt, duty_x10, valid, no_signal
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: high time, period and duty (0.1 % steps) of each full input period.
// Latency: valid 12 cycles after the closing rise (1 cycle with PWM_CAPTURE_DUTY_EN undefined).
// Backpressure: none; captures arriving while the divider is busy are dropped.
module pwm_capture #(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 5_000_000
) (
  input  logic         clk,
  input  logic         reset_n,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} meas_state_e;

  logic             sync1_q, sync2_q, sync3_q;
  logic             rise, fall;
  meas_state_e      meas_q, meas_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] hlat_q, hlat_d;
  logic             capture, timeout;

  logic             res_done;
  logic [CNT_W-1:0] res_high, res_per;
  logic [9:0]       res_duty;

  logic [CNT_W-1:0] high_q, per_q;
  logic [9:0]       duty_q;
  logic             valid_q, nosig_q;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= bus.pwm_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;
  assign fall = ~sync2_q & sync3_q;

  // Measurement state, run counter and latched high time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meas_q <= IDLE;
      run_q  <= '0;
      hlat_q <= '0;
    end else begin
      meas_q <= meas_d;
      run_q  <= run_d;
      hlat_q <= hlat_d;
    end
  end

  // MEASURE = high phase after a rise, ARMED = low phase with high time latched.
  // A rise in ARMED closes the period; a rise always beats the timeout.
  always_comb begin
    meas_d  = meas_q;
    run_d   = run_q;
    hlat_d  = hlat_q;
    capture = 1'b0;
    timeout = 1'b0;
    case (meas_q)
      IDLE: begin
        if (rise) begin
          meas_d = MEASURE;
          run_d  = ONE;
        end
      end
      MEASURE, ARMED: begin
        if (rise) begin
          capture = (meas_q == ARMED);
          meas_d  = MEASURE;
          run_d   = ONE;
        end else if (run_q == TO_CNT) begin
          timeout = 1'b1;
          meas_d  = IDLE;
          run_d   = '0;
        end else begin
          run_d = run_q + ONE;
          if (fall && meas_q == MEASURE) begin
            hlat_d = run_q;
            meas_d = ARMED;
          end
        end
      end
      default: meas_d = IDLE;
    endcase
  end

`ifdef PWM_CAPTURE_DUTY_EN
  typedef enum logic [1:0] {RIDLE, DIV, DONE} res_state_e;

  res_state_e        res_q, res_d;
  logic [3:0]        iter_q, iter_d;
  logic [CNT_W+9:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0]  rhigh_q, rhigh_d;
  logic [CNT_W+9:0]  hx, mul1000;
  logic [CNT_W:0]    top;
  logic [CNT_W-1:0]  rem_new;
  logic              qbit;

  // high*1000 as h*1024 - h*16 - h*8; the divide step shifts the remainder
  // left and subtracts the period when it fits. The remainder stays below the
  // divisor, so the difference always fits in CNT_W bits.
  assign hx      = {10'd0, hlat_q};
  assign mul1000 = (hx << 10) - (hx << 4) - (hx << 3);
  assign top     = acc_q[CNT_W+9:9];
  assign qbit    = (top >= {1'b0, dvs_q});
  assign rem_new = qbit ? (top[CNT_W-1:0] - dvs_q) : top[CNT_W-1:0];

  // Divider state and operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q   <= RIDLE;
      iter_q  <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      rhigh_q <= '0;
    end else begin
      res_q   <= res_d;
      iter_q  <= iter_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      rhigh_q <= rhigh_d;
    end
  end

  // Load on capture, 10 restoring steps MSB first, then one DONE cycle.
  always_comb begin
    res_d    = res_q;
    iter_d   = iter_q;
    acc_d    = acc_q;
    dvs_d    = dvs_q;
    rhigh_d  = rhigh_q;
    res_done = 1'b0;
    case (res_q)
      RIDLE: begin
        if (capture) begin
          acc_d   = mul1000;
          dvs_d   = run_q;
          rhigh_d = hlat_q;
          iter_d  = '0;
          res_d   = DIV;
        end
      end
      DIV: begin
        acc_d  = {rem_new, acc_q[8:0], qbit};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd9) res_d = DONE;
      end
      DONE: begin
        res_done = 1'b1;
        res_d    = RIDLE;
      end
      default: res_d = RIDLE;
    endcase
  end

  assign res_high = rhigh_q;
  assign res_per  = dvs_q;
  assign res_duty = acc_q[9:0];
`else
  assign res_done = capture;
  assign res_high = hlat_q;
  assign res_per  = run_q;
  assign res_duty = '0;
`endif

  // Result registers: only ever updated together with the valid pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_q  <= '0;
      per_q   <= '0;
      duty_q  <= '0;
      valid_q <= 1'b0;
      nosig_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (timeout) begin
        high_q  <= '0;
        per_q   <= '0;
        duty_q  <= sync2_q ? 10'd1000 : 10'd0;
        nosig_q <= 1'b1;
        valid_q <= 1'b1;
      end else if (res_done) begin
        high_q  <= res_high;
        per_q   <= res_per;
        duty_q  <= res_duty;
        nosig_q <= 1'b0;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.high_cnt   = high_q;
  assign bus.period_cnt = per_q;
  assign bus.duty_x10   = duty_q;
  assign bus.valid      = valid_q;
  assign bus.no_signal  = nosig_q;

endmodule
